memory_stage_controller: RTL and testbench

- Sequences every data-memory access issued by the execute-to-memory pipeline register.
- Latches the access, drives a request/acknowledge memory port with byte enables and lane-aligned write data, then sign/zero-extends load data.
- Holds the upstream pipeline stalled until the access completes or times out.
- Sits between the execute-to-memory register and the memory-to-writeback register.

---
 rtl/memory_stage_controller.sv | 188 ++++++++++++++++++
 tb/tb_memory_stage_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage_controller.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage_controller
// Description : Sequences data-memory loads/stores from the EX/MEM register.
//               Latches the access, drives a req/ack memory port with byte
//               enables and lane-replicated write data, extends load data and
//               stalls the upstream pipeline until completion or timeout.
//               Optional macro MISALIGN_TRAP_EN traps misaligned half/word
//               accesses without issuing a memory request.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage_controller #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  memoryReadEnable,
    input  logic                  memoryWriteEnable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           writeData,
    input  logic [2:0]            func3,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [31:0]           memWdata,
    output logic [3:0]            memByteEn,
    input  logic                  memAck,
    input  logic [31:0]           memRdata,
    output logic [31:0]           loadData,
    output logic                  loadValid,
    output logic                  stall,
    output logic                  busError,
    output logic                  misaligned
);

    // Last counter value before the access is abandoned.
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [2:0]            func3_q, func3_d;
    logic                  we_q, we_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [31:0]           load_q, load_d;
    logic                  buserr_q, buserr_d;
    logic                  mis_q, mis_d;

    logic                  w_req;
    logic                  w_in_mis;
    logic                  w_is_byte;
    logic                  w_is_half;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_ext;

    assign w_req = memoryReadEnable | memoryWriteEnable;

    // func3[1:0] = 00 is a byte and 01 a half; every other code is a word.
    assign w_is_byte = (func3_q[1:0] == 2'b00);
    assign w_is_half = (func3_q[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
    // Half needs addr[0] = 0; word (including unknown codes) needs addr[1:0] = 0.
    assign w_in_mis = ((func3[1:0] == 2'b01) && address[0]) ||
                      (func3[1]  && (address[1:0] != 2'b00)) ||
                      ((func3[1:0] == 2'b11) && (address[1:0] != 2'b00));
`else
    assign w_in_mis = 1'b0;
`endif

    // Pick the addressed byte/halfword out of the read word and extend it.
    always_comb begin
        w_byte = memRdata[7:0];
        case (addr_q[1:0])
            2'd0:    w_byte = memRdata[7:0];
            2'd1:    w_byte = memRdata[15:8];
            2'd2:    w_byte = memRdata[23:16];
            default: w_byte = memRdata[31:24];
        endcase
        w_half = addr_q[1] ? memRdata[31:16] : memRdata[15:0];
        if (w_is_byte)
            w_ext = {{24{w_byte[7] & ~func3_q[2]}}, w_byte};
        else if (w_is_half)
            w_ext = {{16{w_half[15] & ~func3_q[2]}}, w_half};
        else
            w_ext = memRdata;
    end

    // State and latched-access registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            func3_q  <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            load_q   <= '0;
            buserr_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            func3_q  <= func3_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            load_q   <= load_d;
            buserr_q <= buserr_d;
            mis_q    <= mis_d;
        end
    end

    // Next-state logic: accept in IDLE, wait for ack or timeout in ACCESS.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        func3_d  = func3_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        load_d   = load_q;
        buserr_d = buserr_q;
        mis_d    = mis_q;
        case (state_q)
            IDLE: begin
                if (w_req) begin
                    addr_d   = address;
                    wdata_d  = writeData;
                    func3_d  = func3;
                    we_d     = ~memoryReadEnable;   // read wins if both set
                    cnt_d    = '0;
                    load_d   = '0;
                    buserr_d = 1'b0;
                    mis_d    = w_in_mis;
                    state_d  = w_in_mis ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (memAck) begin
                    load_d  = we_q ? 32'd0 : w_ext;
                    state_d = DONE;
                end else if (cnt_q == c_TO_LAST) begin
                    buserr_d = 1'b1;
                    load_d   = '0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory port driven from latched values while the request is up.
    always_comb begin
        memReq = (state_q == ACCESS);
        memWe  = memReq & we_q;
        memAddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        if (w_is_byte) begin
            memByteEn = 4'b0001 << addr_q[1:0];
            memWdata  = {4{wdata_q[7:0]}};
        end else if (w_is_half) begin
            memByteEn = 4'b0011 << {addr_q[1], 1'b0};
            memWdata  = {2{wdata_q[15:0]}};
        end else begin
            memByteEn = 4'b1111;
            memWdata  = wdata_q;
        end
        // The IDLE term is combinational, so gate it with reset to drop at once.
        stall      = (state_q == ACCESS) | ((state_q == IDLE) & w_req & reset);
        loadValid  = (state_q == DONE);
        loadData   = load_q;
        busError   = buserr_q;
        misaligned = loadValid & mis_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_stage_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_stage_controller
// Description : Table-driven bench for memory_stage_controller plus directed
//               reset-abort and (with MISALIGN_TRAP_EN) misalignment sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_stage_controller;

    localparam int AW     = 32;
    localparam int TO     = 16;
    localparam int NO_ACK = 255;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          memoryReadEnable = 1'b0;
    logic          memoryWriteEnable = 1'b0;
    logic [AW-1:0] address = '0;
    logic [31:0]   writeData = '0;
    logic [2:0]    func3 = '0;
    logic          memReq;
    logic          memWe;
    logic [AW-1:0] memAddr;
    logic [31:0]   memWdata;
    logic [3:0]    memByteEn;
    logic          memAck = 1'b0;
    logic [31:0]   memRdata = '0;
    logic [31:0]   loadData;
    logic          loadValid;
    logic          stall;
    logic          busError;
    logic          misaligned;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    memory_stage_controller #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .memoryReadEnable(memoryReadEnable), .memoryWriteEnable(memoryWriteEnable),
        .address(address), .writeData(writeData), .func3(func3),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memByteEn(memByteEn), .memAck(memAck), .memRdata(memRdata),
        .loadData(loadData), .loadValid(loadValid), .stall(stall),
        .busError(busError), .misaligned(misaligned)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        int          dly;      // memAck this many cycles after memReq rises
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic [31:0] load;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          req_cnt;
        int          stall_cnt;
        int          exp_req;
        logic        stable_ok;
        logic        finished;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic        timeout;
        timeout  = (v.dly == NO_ACK);
        exp_addr = v.addr & 32'hFFFF_FFFC;
        exp_we   = v.wr & ~v.rd;
        exp_req  = timeout ? TO : v.dly + 1;
        @(posedge clock); #1;
        memoryReadEnable  = v.rd;
        memoryWriteEnable = v.wr;
        address   = v.addr;
        writeData = v.wdata;
        func3     = v.f3;
        memRdata  = v.rdata;
        req_cnt   = 0;
        stall_cnt = 0;
        stable_ok = 1'b1;
        finished  = 1'b0;
        for (int k = 0; k < 64 && !finished; k++) begin
            #1;
            if (k == 0) check($sformatf("v%0d_stall_accept", idx), {31'd0, stall}, 32'd1);
            if (loadValid) begin
                finished = 1'b1;
                check($sformatf("v%0d_req_cycles", idx), req_cnt, exp_req);
                check($sformatf("v%0d_stall_cycles", idx), stall_cnt, exp_req + 1);
                check($sformatf("v%0d_stall_done", idx), {31'd0, stall}, 32'd0);
                check($sformatf("v%0d_req_done", idx), {31'd0, memReq}, 32'd0);
                check($sformatf("v%0d_buserr", idx), {31'd0, busError}, {31'd0, timeout});
                check($sformatf("v%0d_misaligned", idx), {31'd0, misaligned}, 32'd0);
                check($sformatf("v%0d_stable", idx), {31'd0, stable_ok}, 32'd1);
                if (!exp_we)
                    check($sformatf("v%0d_loaddata", idx), loadData, timeout ? 32'd0 : v.load);
            end else begin
                if (stall) stall_cnt++;
                if (memReq) begin
                    req_cnt++;
                    if (req_cnt == 1) begin
                        check($sformatf("v%0d_memaddr", idx), memAddr, exp_addr);
                        check($sformatf("v%0d_byteen", idx), {28'd0, memByteEn}, {28'd0, v.be});
                        check($sformatf("v%0d_memwe", idx), {31'd0, memWe}, {31'd0, exp_we});
                        check($sformatf("v%0d_buserr_clr", idx), {31'd0, busError}, 32'd0);
                        if (exp_we) check($sformatf("v%0d_memwdata", idx), memWdata, v.mwd);
                    end else begin
                        stable_ok &= (memAddr == exp_addr) && (memByteEn == v.be) &&
                                     (memWe == exp_we) && (!exp_we || memWdata == v.mwd);
                    end
                    memAck = !timeout && (req_cnt == v.dly + 1);
                end
                @(posedge clock); #1;
                memoryReadEnable  = 1'b0;
                memoryWriteEnable = 1'b0;
                memAck            = 1'b0;
            end
        end
        check($sformatf("v%0d_completed", idx), {31'd0, finished}, 32'd1);
        @(posedge clock); #2;
        check($sformatf("v%0d_valid_pulse", idx), {31'd0, loadValid}, 32'd0);
    endtask

    initial begin
        //           rd    wr    addr          wdata         f3      dly     rdata         be       mwd           load
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 2,      32'h0,        4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0203, 32'h0000_00A5, 3'b000, 0,      32'h0,        4'b1000, 32'hA5A5_A5A5, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0203, 32'h0,         3'b000, 1,      32'h8012_3456, 4'b1000, 32'h0,        32'hFFFF_FF80};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0203, 32'h0,         3'b100, 3,      32'h8012_3456, 4'b1000, 32'h0,        32'h0000_0080};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0302, 32'h0,         3'b001, 0,      32'h8001_1234, 4'b1100, 32'h0,        32'hFFFF_8001};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,         3'b101, 1,      32'h8001_9234, 4'b0011, 32'h0,        32'h0000_9234};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0102, 32'h1234_ABCD, 3'b001, 1,      32'h0,        4'b1100, 32'hABCD_ABCD, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_0040, 32'h5555_5555, 3'b010, 0,      32'hCAFE_F00D, 4'b1111, 32'h0,        32'hCAFE_F00D};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0001, 32'h0,         3'b000, 2,      32'h0000_7F00, 4'b0010, 32'h0,        32'h0000_007F};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         3'b111, 0,      32'h1234_5678, 4'b1111, 32'h0,        32'h1234_5678};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,         3'b010, NO_ACK, 32'h9999_9999, 4'b1111, 32'h0,        32'h0};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0084, 32'h0,         3'b010, 1,      32'hA5A5_0001, 4'b1111, 32'h0,        32'hA5A5_0001};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_memreq", {31'd0, memReq}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_loadvalid", {31'd0, loadValid}, 32'd0);
        check("rst_buserr", {31'd0, busError}, 32'd0);
        check("rst_loaddata", loadData, 32'd0);
        check("rst_misaligned", {31'd0, misaligned}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Reset asserted in the middle of an access
        @(posedge clock); #1;
        memoryReadEnable = 1'b1;
        address = 32'h0000_0500;
        func3   = 3'b010;
        @(posedge clock); #1;
        memoryReadEnable = 1'b0;
        @(posedge clock); #1;
        check("abort_req_before", {31'd0, memReq}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_memreq", {31'd0, memReq}, 32'd0);
        check("abort_stall", {31'd0, stall}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("abort_idle_req", {31'd0, memReq}, 32'd0);
        check("abort_no_valid", {31'd0, loadValid}, 32'd0);

`ifdef MISALIGN_TRAP_EN
        // Misaligned word load is trapped without a memory request
        @(posedge clock); #1;
        memoryReadEnable = 1'b1;
        address = 32'h0000_0102;
        func3   = 3'b010;
        #1;
        check("mis_stall", {31'd0, stall}, 32'd1);
        @(posedge clock); #1;
        memoryReadEnable = 1'b0;
        #1;
        check("mis_noreq", {31'd0, memReq}, 32'd0);
        check("mis_valid", {31'd0, loadValid}, 32'd1);
        check("mis_flag", {31'd0, misaligned}, 32'd1);
        check("mis_loaddata", loadData, 32'd0);
        check("mis_stall_done", {31'd0, stall}, 32'd0);
        @(posedge clock); #2;
        check("mis_pulse", {31'd0, misaligned}, 32'd0);
        check("mis_noreq_after", {31'd0, memReq}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
